mem_port_arbiter: RTL

//  Shares one memory port between NUM_REQ cache clients (dcache, icache, ...) with the dcache-style mem_* handshake.

---
 rtl/mem_port_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one mem_* port among NUM_REQ cache clients, one locked transaction at a time.
// Define MEM_PORT_ARB_STATS_EN to add per-requester grant/wait statistics counters and their ports.
module mem_port_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
`ifdef MEM_PORT_ARB_STATS_EN
    input  logic                          stat_clr,
    output logic [NUM_REQ*32-1:0]         stat_grants,
    output logic [NUM_REQ*32-1:0]         stat_wait,
`endif
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         req_rdata,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic                          mem_ready,
    input  logic [DATA_WIDTH-1:0]         mem_rdata
);

    // Handshake: a requester holds req_valid and its fields stable until req_ready pulses
    // (transaction done) or it withdraws req_valid (abort); mem_ready is a single-cycle
    // completion strobe that is only honoured while a grant is held.

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [NUM_REQ-1:0]   grant_q;
    logic [NUM_REQ-1:0]   grant_next;
    logic [IDX_W-1:0]     gidx_q;
    logic [IDX_W-1:0]     gidx_next;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [IDX_W-1:0]     rr_ptr_next;
    logic [IDX_W-1:0]     rr_inc;

    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     hi_idx;
    logic [IDX_W-1:0]     lo_idx;
    logic                 hi_found;

    logic                 busy;
    logic                 g_valid;
    logic                 g_we;
    logic [ADDR_WIDTH-1:0] g_addr;
    logic [DATA_WIDTH-1:0] g_wdata;

    assign busy = (state == BUSY);

    // Round-robin pick: lowest requester at or above rr_ptr, else lowest overall (wrap).
    always_comb begin
        hi_idx   = '0;
        lo_idx   = '0;
        hi_found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_idx = IDX_W'(i);
                if (IDX_W'(i) >= rr_ptr_q) begin
                    hi_idx   = IDX_W'(i);
                    hi_found = 1'b1;
                end
            end
        end
        pick_idx = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        g_valid = 1'b0;
        g_we    = 1'b0;
        g_addr  = '0;
        g_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gidx_q == IDX_W'(i)) begin
                g_valid = req_valid[i];
                g_we    = req_we[i];
                g_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                g_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign rr_inc = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);

    always_comb begin
        state_next  = state;
        grant_next  = grant_q;
        gidx_next   = gidx_q;
        rr_ptr_next = rr_ptr_q;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    state_next = BUSY;
                    gidx_next  = pick_idx;
                    grant_next = NUM_REQ'(1) << pick_idx;
                end
            end
            BUSY: begin
                // Completion and abort both release the port and move the pointer past g.
                if (mem_ready || !g_valid) begin
                    state_next  = IDLE;
                    grant_next  = '0;
                    rr_ptr_next = rr_inc;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            state    <= state_next;
            grant_q  <= grant_next;
            gidx_q   <= gidx_next;
            rr_ptr_q <= rr_ptr_next;
        end
    end

    assign grant     = grant_q;
    assign mem_req   = busy & (g_valid | mem_ready);
    assign mem_we    = busy & g_we;
    assign mem_addr  = busy ? g_addr : '0;
    assign mem_wdata = busy ? g_wdata : '0;
    assign req_ready = busy ? (grant_q & {NUM_REQ{mem_ready}}) : '0;
    assign req_rdata = mem_rdata;

`ifdef MEM_PORT_ARB_STATS_EN
    logic [31:0] grants_cnt [NUM_REQ];
    logic [31:0] wait_cnt   [NUM_REQ];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst || stat_clr) begin
                grants_cnt[i] <= '0;
                wait_cnt[i]   <= '0;
            end else begin
                if (busy && mem_ready && grant_q[i] && (grants_cnt[i] != 32'hFFFF_FFFF))
                    grants_cnt[i] <= grants_cnt[i] + 32'd1;
                if (req_valid[i] && !grant_q[i] && (wait_cnt[i] != 32'hFFFF_FFFF))
                    wait_cnt[i] <= wait_cnt[i] + 32'd1;
            end
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat_pack
        assign stat_grants[i*32 +: 32] = grants_cnt[i];
        assign stat_wait[i*32 +: 32]   = wait_cnt[i];
    end
`endif

endmodule
